// File: rtl/regset_param_sb.sv
// Parametrised register file: two combinational read ports with write bypass,
// one synchronous write port and a per-register busy scoreboard.
module regset_param_sb #(
    parameter int WIDTH   = 6,
    parameter int ADDR_W  = 3,
    parameter int NREGS   = 5,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wrd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              rdy_a,
    output logic              rdy_b,
    output logic [NREGS-1:0]  busy
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy_q;

    // A hardwired r0 behaves exactly like an unimplemented address.
    function automatic logic reg_ok(input int idx);
        return (idx < NREGS) && !((ZERO_R0 != 0) && (idx == 0));
    endfunction

    logic wr_hit;
    assign wr_hit = we && reg_ok(int'(wr));

    // NOTE: the storage array is reset along with the scoreboard because the
    // consumer expects every register to read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_ok(i)) begin
                    if (wr_hit && int'(wr) == i) regs[i] <= wrd;
                    // A same-cycle issue names a newer producer, so it beats the clear.
                    if (iss && int'(iss_rd) == i)
                        busy_q[i] <= 1'b1;
                    else if (wr_hit && int'(wr) == i)
                        busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: every variable below gets a default before the loop so no latch
    // is inferred for addresses that match nothing.
    always_comb begin
        logic [WIDTH-1:0] sa, sb;
        logic             ba, bb;
        sa = '0;
        sb = '0;
        ba = 1'b0;
        bb = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_ok(i) && int'(ra) == i) begin
                sa = regs[i];
                ba = busy_q[i];
            end
            if (reg_ok(i) && int'(rb) == i) begin
                sb = regs[i];
                bb = busy_q[i];
            end
        end
        a     = (wr_hit && wr == ra) ? wrd : sa;
        b     = (wr_hit && wr == rb) ? wrd : sb;
        rdy_a = !ba || (wr_hit && wr == ra);
        rdy_b = !bb || (wr_hit && wr == rb);
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regset_param_sb.sv
// Bench for regset_param_sb: directed vector table, reset corner cases and a
// randomized run, with a default instance and a hardwired-r0 instance.
module tb_regset_param_sb;

    logic       clk, rst_n;
    logic       we, iss;
    logic [2:0] wr, ra, rb, iss_rd;
    logic [5:0] wrd;
    logic [5:0] a0, b0, a1, b1;
    logic       rdy_a0, rdy_b0, rdy_a1, rdy_b1;
    logic [4:0] busy0, busy1;

    int vectors = 0;
    int miscompares = 0;

    regset_param_sb #(.WIDTH(6), .ADDR_W(3), .NREGS(5), .ZERO_R0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .wr(wr), .wrd(wrd), .ra(ra), .rb(rb),
        .a(a0), .b(b0), .iss(iss), .iss_rd(iss_rd), .rdy_a(rdy_a0), .rdy_b(rdy_b0),
        .busy(busy0));

    regset_param_sb #(.WIDTH(6), .ADDR_W(3), .NREGS(5), .ZERO_R0(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .wr(wr), .wrd(wrd), .ra(ra), .rb(rb),
        .a(a1), .b(b1), .iss(iss), .iss_rd(iss_rd), .rdy_a(rdy_a1), .rdy_b(rdy_b1),
        .busy(busy1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays indexed by [instance][address].
    logic [5:0] m_reg  [2][8];
    logic       m_busy [2][8];

    function automatic bit m_valid(input int z, input int adr);
        return adr < 5 && !(z == 1 && adr == 0);
    endfunction

    function automatic logic [5:0] m_read(input int z, input int adr);
        if (!m_valid(z, adr)) return 6'h00;
        if (we && int'(wr) == adr) return wrd;
        return m_reg[z][adr];
    endfunction

    function automatic logic m_rdy(input int z, input int adr);
        return !m_valid(z, adr) || !m_busy[z][adr] || (we && int'(wr) == adr);
    endfunction

    function automatic logic [4:0] m_busyvec(input int z);
        logic [4:0] v;
        for (int i = 0; i < 5; i++) v[i] = m_busy[z][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 8; i++) begin
                m_reg[z][i]  = 6'h00;
                m_busy[z][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (we && m_valid(z, int'(wr))) begin
                m_reg[z][wr]  = wrd;
                m_busy[z][wr] = 1'b0;
            end
            if (iss && m_valid(z, int'(iss_rd))) m_busy[z][iss_rd] = 1'b1;
        end
    endtask

    task automatic compare_model();
        check("m0_a", a0, m_read(0, int'(ra)));
        check("m0_b", b0, m_read(0, int'(rb)));
        check("m0_rdy_a", rdy_a0, m_rdy(0, int'(ra)));
        check("m0_rdy_b", rdy_b0, m_rdy(0, int'(rb)));
        check("m0_busy", busy0, m_busyvec(0));
        check("m1_a", a1, m_read(1, int'(ra)));
        check("m1_b", b1, m_read(1, int'(rb)));
        check("m1_rdy_a", rdy_a1, m_rdy(1, int'(ra)));
        check("m1_rdy_b", rdy_b1, m_rdy(1, int'(rb)));
        check("m1_busy", busy1, m_busyvec(1));
    endtask

    typedef struct {
        logic       we;
        logic [2:0] wr;
        logic [5:0] wrd;
        logic [2:0] ra, rb;
        logic       iss;
        logic [2:0] iss_rd;
        logic [5:0] a, b;
        logic       rdy_a, rdy_b;
        logic [4:0] busy;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [5:0] wd,
                                input logic [2:0] xa, input logic [2:0] xb, input logic is,
                                input logic [2:0] ir, input logic [5:0] ea, input logic [5:0] eb,
                                input logic era, input logic erb, input logic [4:0] eby);
        vec_t v;
        v.we = w; v.wr = wa; v.wrd = wd; v.ra = xa; v.rb = xb; v.iss = is; v.iss_rd = ir;
        v.a = ea; v.b = eb; v.rdy_a = era; v.rdy_b = erb; v.busy = eby;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        //            we wr wrd    ra rb iss ird  a      b      rA rB busy
        tbl[0]  = mk(1, 3, 6'h2A, 3, 0, 0, 0, 6'h2A, 6'h00, 1, 1, 5'b00000);
        tbl[1]  = mk(0, 0, 6'h00, 3, 3, 0, 0, 6'h2A, 6'h2A, 1, 1, 5'b00000);
        tbl[2]  = mk(1, 6, 6'h11, 6, 3, 0, 0, 6'h00, 6'h2A, 1, 1, 5'b00000);
        tbl[3]  = mk(0, 0, 6'h00, 6, 6, 0, 0, 6'h00, 6'h00, 1, 1, 5'b00000);
        tbl[4]  = mk(1, 2, 6'h01, 2, 3, 0, 0, 6'h01, 6'h2A, 1, 1, 5'b00000);
        tbl[5]  = mk(1, 2, 6'h3F, 2, 2, 0, 0, 6'h3F, 6'h3F, 1, 1, 5'b00000);
        tbl[6]  = mk(0, 0, 6'h00, 2, 0, 0, 0, 6'h3F, 6'h00, 1, 1, 5'b00000);
        tbl[7]  = mk(0, 0, 6'h00, 4, 4, 1, 4, 6'h00, 6'h00, 1, 1, 5'b00000);
        tbl[8]  = mk(0, 0, 6'h00, 4, 2, 0, 0, 6'h00, 6'h3F, 0, 1, 5'b10000);
        tbl[9]  = mk(1, 4, 6'h0A, 4, 4, 0, 0, 6'h0A, 6'h0A, 1, 1, 5'b10000);
        tbl[10] = mk(0, 0, 6'h00, 4, 1, 0, 0, 6'h0A, 6'h00, 1, 1, 5'b00000);
        tbl[11] = mk(0, 0, 6'h00, 1, 0, 1, 1, 6'h00, 6'h00, 1, 1, 5'b00000);
        tbl[12] = mk(1, 1, 6'h15, 1, 4, 1, 1, 6'h15, 6'h0A, 1, 1, 5'b00010);
        tbl[13] = mk(0, 0, 6'h00, 1, 1, 0, 0, 6'h15, 6'h15, 0, 0, 5'b00010);
        tbl[14] = mk(1, 1, 6'h2C, 7, 1, 1, 7, 6'h00, 6'h2C, 1, 1, 5'b00010);
        tbl[15] = mk(0, 0, 6'h00, 1, 7, 0, 0, 6'h2C, 6'h00, 1, 1, 5'b00000);
        tbl[16] = mk(1, 0, 6'h3F, 0, 0, 1, 0, 6'h3F, 6'h3F, 1, 1, 5'b00000);
        tbl[17] = mk(0, 0, 6'h00, 0, 0, 0, 0, 6'h3F, 6'h3F, 0, 0, 5'b00001);

        rst_n = 1'b0;
        we = 1'b0; wr = '0; wrd = '0; ra = '0; rb = '0; iss = 1'b0; iss_rd = '0;
        model_reset();
        #1;
        check("rst_a", a0, 6'h00);
        check("rst_rdy_a", rdy_a0, 1'b1);
        check("rst_busy", busy0, 5'b00000);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            we = tbl[i].we; wr = tbl[i].wr; wrd = tbl[i].wrd;
            ra = tbl[i].ra; rb = tbl[i].rb; iss = tbl[i].iss; iss_rd = tbl[i].iss_rd;
            #3;
            check($sformatf("v%0d_a", i), a0, tbl[i].a);
            check($sformatf("v%0d_b", i), b0, tbl[i].b);
            check($sformatf("v%0d_rdy_a", i), rdy_a0, tbl[i].rdy_a);
            check($sformatf("v%0d_rdy_b", i), rdy_b0, tbl[i].rdy_b);
            check($sformatf("v%0d_busy", i), busy0, tbl[i].busy);
            compare_model();
            @(posedge clk);
            model_edge();
            #1;
        end

        // Hardwired r0 ignored the write and the issue of the last two rows.
        check("z_a", a1, 6'h00);
        check("z_busy", busy1, 5'b00000);
        check("z_rdy_a", rdy_a1, 1'b1);

        // Load r1, then assert reset between edges with a write pending.
        we = 1'b1; wr = 3'd1; wrd = 6'h15; iss = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        we = 1'b0; ra = 3'd1; rb = 3'd1;
        #2;
        check("pre_rst_a", a0, 6'h15);
        we = 1'b1; wr = 3'd2; wrd = 6'h2B;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", a0, 6'h00);
        check("async_rst_b", b0, 6'h00);
        check("async_rst_busy", busy0, 5'b00000);
        check("async_rst_rdy", rdy_a0, 1'b1);
        @(posedge clk);
        #1;
        we = 1'b0; ra = 3'd2; rb = 3'd1;
        #1;
        check("rst_drop_wr", a0, 6'h00);
        model_reset();
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_r1", b0, 6'h00);
        compare_model();
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            we     = 1'($urandom_range(0, 1));
            wr     = 3'($urandom_range(0, 7));
            wrd    = 6'($urandom);
            ra     = 3'($urandom_range(0, 7));
            rb     = 3'($urandom_range(0, 7));
            iss    = 1'($urandom_range(0, 2) == 0);
            iss_rd = 3'($urandom_range(0, 7));
            if (n % 5 == 0) rb = wr;
            if (n % 7 == 0) iss_rd = wr;
            #3;
            compare_model();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
